rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Two-port arbiter and access sequencer for the shared instruction/constant ROM (DATA_WIDTH-bit data, combinational address-to-data read with an `error` flag). It accepts read requests from two independent requesters, such as instruction fetch (port 0) and the load unit (port 1), over valid/ready handshakes. It grants the ROM to one requester at a time using round-robin priority and drives a registered address into the ROM. It then returns the captured data and error status to the granted requester.

## Interface

Parameters:
- `DATA_WIDTH`, 16: ROM word width.
- `ADDR_WIDTH`, 8: ROM address width.
- `ROM_DEPTH`, 256: number of valid words; addresses >= ROM_DEPTH are out of range.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request pending on port k.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_addr` / `req1_addr`  in  ADDR_WIDTH  word address for port k.
- `rsp0_valid` / `rsp1_valid`  out  1  response available on port k.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the response.
- `rsp0_data` / `rsp1_data`  out  DATA_WIDTH  read data.
- `rsp0_error` / `rsp1_error`  out  1  ROM error, or address out of range.
- `rom_addr`  out  ADDR_WIDTH  registered address to the ROM.
- `rom_data`  in  DATA_WIDTH  ROM read data, combinational from `rom_addr`.
- `rom_error`  in  1  ROM error flag, combinational from `rom_addr`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

State machine states: IDLE, ACCESS, RESP.

- **IDLE:**
  - Grant is computed combinationally.
  - If only one `reqk_valid` is high, that port is granted.
  - If both are high, the port other than `last_grant` is granted.
  - `reqk_ready` = (state==IDLE) && granted==k. Ready may depend on valid; valid must never depend on ready.
  - On accept: `rom_addr` <= `reqk_addr`; `cur` <= k; `oor` <= (`reqk_addr` >= ROM_DEPTH); go to ACCESS.
  - With no request pending, remain in IDLE; `rom_addr` holds its value.
- **ACCESS:**
  - Capture `rsp_data` <= `rom_data` and `rsp_err` <= `rom_error` | `oor`.
  - Set `rsp_valid` for port `cur`; go to RESP.
- **RESP:**
  - `rsp{cur}_valid` = 1; `rsp{cur}_data` and `rsp{cur}_error` are held stable.
  - On `rsp{cur}_ready`: clear valid, `last_grant` <= `cur`, go to IDLE.
  - `rsp_ready` on the non-current port is ignored.
- **Data outputs:** both `rspk_data` ports are driven from the shared capture register. Only the port whose valid is high is meaningful; the other port's error output is 0.
- **Flow control:**
  - At most one transaction is in flight.
  - No request is accepted while in ACCESS or RESP; both `req_ready` are 0.
  - A requester holding `req_valid` keeps its address stable until accepted.
- **Out of range:** an out-of-range address still goes to the ROM unchanged. `rsp_error` is forced to 1; the data is whatever the ROM returns.

## Timing

- **Reset values:** state IDLE; `last_grant`=1, so port 0 wins the first contention. `rom_addr`, capture registers, both `rsp_valid`, both `rsp_error` and `busy` are all 0. Both `req_ready` are 0 while `rst` is high.
- **Latency:** accept in cycle T → `rom_addr` valid in T+1 → `rsp_valid` high in T+2.
- **Throughput:** with `rsp_ready` held high, the next accept happens in T+3, giving one access per 3 cycles.
- **Response backpressure:** while `rsp_ready` is low, RESP is held indefinitely with data and error stable. No new grant happens and `last_grant` is unchanged.
- **Simultaneous events:**
  - Both requests arriving in the same IDLE cycle: exactly one `req_ready` is asserted.
  - The loser keeps valid high and is granted in the next IDLE cycle, so it is never starved.
- **Reset mid-operation:** `rst` asserted in ACCESS or RESP aborts the transaction. No response is delivered, and outputs return to their reset values on the next edge.
- **ROM input sampling:** `rom_data` and `rom_error` are sampled only at the end of the ACCESS cycle; changes in any other cycle have no effect.

## Test plan

- **Reset:** hold `rst` for 3 cycles with both `req_valid`=1 → both `req_ready`=0, both `rsp_valid`=0, `rom_addr`=0, `busy`=0; first grant after reset goes to port 0.
- **Single read:**
  - Stimulus: port 0 requests address 0x10, ROM model returns 0xBEEF for it, `rsp0_ready`=1.
  - Required response: `req0_ready` in T, `rom_addr`=0x10 in T+1, `rsp0_valid`=1 with `rsp0_data`=0xBEEF and `rsp0_error`=0 in T+2, `busy` low in T+3.
- **Contention and round-robin:**
  - Stimulus: both ports held valid with addresses 0x01 and 0x02.
  - Required response: grants alternate 0,1,0,1 over 4 transactions; each port receives its own ROM word.
- **Response backpressure:**
  - Stimulus: `rsp1_ready` held low for 5 cycles after `rsp1_valid` rises; port 0 requesting throughout.
  - Required response: `rsp1_valid`, `rsp1_data` and `rsp1_error` stay stable; `req0_ready` stays 0; port 0 is granted in the cycle after the handshake completes.
- **Error paths:**
  - Stimulus: ROM model asserts `rom_error` for address 0x05; `ROM_DEPTH`=32 and address 0x40 is requested.
  - Required response: both responses arrive with `rsp_error`=1; a following read of 0x06 returns `rsp_error`=0.
- **Reset mid-transaction:**
  - Stimulus: `rst` pulsed for 1 cycle while in RESP with `rsp0_valid`=1.
  - Required response: `rsp0_valid`=0 the next cycle, state is IDLE, and a pending port 1 request is not granted until `rst` is low.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Request/response channel between one ROM requester and the arbiter.
// The requester side uses the master modport, the arbiter uses slave.
interface rom_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_error;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter for a shared combinational ROM.
// One access is in flight at a time: IDLE grants and registers the
// address, ACCESS captures the ROM word, RESP holds it until consumed.
module rom_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int ROM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    rom_arbiter_if.slave          port0,
    rom_arbiter_if.slave          port1,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_error,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // One extra bit so a depth equal to 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(ROM_DEPTH);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cur_q, cur_d;
    logic                  oor_q, oor_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  grant_valid;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  cur_rsp_ready;
    logic                  in_resp;

    // Round-robin choice: a lone requester wins, otherwise the port that was not served last.
    always_comb begin
        grant_valid = port0.req_valid | port1.req_valid;
        grant       = 1'b0;
        if (port0.req_valid && port1.req_valid) begin
            grant = ~last_grant_q;
        end else if (port1.req_valid) begin
            grant = 1'b1;
        end
        grant_addr    = grant ? port1.req_addr : port0.req_addr;
        cur_rsp_ready = cur_q ? port1.rsp_ready : port0.rsp_ready;
    end

    // Next-state logic for the access sequencer and its capture registers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_d        = cur_q;
        oor_d        = oor_q;
        rom_addr_d   = rom_addr_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    rom_addr_d = grant_addr;
                    cur_d      = grant;
                    oor_d      = ({1'b0, grant_addr} >= DEPTH_LIMIT);
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                rsp_data_d = rom_data;
                rsp_err_d  = rom_error | oor_q;
                state_d    = RESP;
            end
            RESP: begin
                if (cur_rsp_ready) begin
                    last_grant_d = cur_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs; the idle port never sees a response or an error.
    always_comb begin
        in_resp         = (state_q == RESP);
        port0.req_ready = !rst && (state_q == IDLE) && grant_valid && !grant;
        port1.req_ready = !rst && (state_q == IDLE) && grant_valid && grant;
        port0.rsp_valid = in_resp && !cur_q;
        port1.rsp_valid = in_resp && cur_q;
        port0.rsp_data  = rsp_data_q;
        port1.rsp_data  = rsp_data_q;
        port0.rsp_error = in_resp && !cur_q && rsp_err_q;
        port1.rsp_error = in_resp && cur_q && rsp_err_q;
        rom_addr        = rom_addr_q;
        busy            = (state_q != IDLE);
    end

    // State and capture registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cur_q        <= 1'b0;
            oor_q        <= 1'b0;
            rom_addr_q   <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_q        <= cur_d;
            oor_q        <= oor_d;
            rom_addr_q   <= rom_addr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: scripted vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level model.
module tb_rom_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_error;
    logic          busy;

    logic [DW-1:0] rom_mem [256];
    logic          rom_err_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    rom_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p0 ();
    rom_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1 ();

    rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .port0     (p0),
        .port1     (p1),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_error (rom_error),
        .busy      (busy)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Combinational ROM model
    assign rom_data  = rom_mem[rom_addr];
    assign rom_error = rom_err_mem[rom_addr];

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic          v1;
        logic [AW-1:0] a1;
        logic          rr0;
        logic          rr1;
        logic          e_rdy0;
        logic          e_rdy1;
        logic          e_rv0;
        logic          e_rv1;
        logic          e_busy;
        logic          e_err0;
        logic          e_err1;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic v0, logic [AW-1:0] a0, logic v1, logic [AW-1:0] a1,
                                logic rr0, logic rr1, logic rdy0, logic rdy1, logic rv0,
                                logic rv1, logic bsy, logic er0, logic er1,
                                logic [AW-1:0] ad, logic [DW-1:0] d);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.rr0 = rr0; v.rr1 = rr1;
        v.e_rdy0 = rdy0; v.e_rdy1 = rdy1; v.e_rv0 = rv0; v.e_rv1 = rv1;
        v.e_busy = bsy; v.e_err0 = er0; v.e_err1 = er1; v.e_addr = ad; v.e_data = d;
        return v;
    endfunction

    // Drive inputs just after the falling edge and let outputs settle
    task automatic applyStimulus(input logic r, input logic v0, input logic [AW-1:0] a0,
                                 input logic v1, input logic [AW-1:0] a1,
                                 input logic rr0, input logic rr1);
        @(negedge clk);
        rst          = r;
        p0.req_valid = v0;
        p0.req_addr  = a0;
        p1.req_valid = v1;
        p1.req_addr  = a1;
        p0.rsp_ready = rr0;
        p1.rsp_ready = rr1;
        #1;
    endtask

    // Compare control outputs, ROM address and (when a response is valid) data
    task automatic checkOutput(input string name, input logic rdy0, input logic rdy1,
                               input logic rv0, input logic rv1, input logic bsy,
                               input logic er0, input logic er1,
                               input logic [AW-1:0] ad, input logic [DW-1:0] d);
        logic [6:0]    got_c;
        logic [6:0]    exp_c;
        logic [DW-1:0] got_d;
        got_c = {p0.req_ready, p1.req_ready, p0.rsp_valid, p1.rsp_valid, busy,
                 p0.rsp_error, p1.rsp_error};
        exp_c = {rdy0, rdy1, rv0, rv1, bsy, er0, er1};
        n_checks++;
        if (got_c !== exp_c || rom_addr !== ad) begin
            n_errors++;
            $display("[TB] FAIL %s: got rdy/rv/busy/err=%b rom_addr=%h, expected %b rom_addr=%h",
                     name, got_c, rom_addr, exp_c, ad);
        end
        if (rv0 || rv1) begin
            got_d = rv1 ? p1.rsp_data : p0.rsp_data;
            n_checks++;
            if (got_d !== d) begin
                n_errors++;
                $display("[TB] FAIL %s data: got %h, expected %h", name, got_d, d);
            end
        end
    endtask

    // Transaction-level reference model state for the random phase
    logic          m_busy;
    logic          m_in_access;
    logic          m_port;
    logic          m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_err;

    initial begin
        logic          pend0, pend1, v0, v1, rr0, rr1, gv, g;
        logic [AW-1:0] a0, a1;
        logic          e_rdy0, e_rdy1, e_rv0, e_rv1, e_err0, e_err1;

        p0.req_valid = 1'b0; p0.req_addr = '0; p0.rsp_ready = 1'b0;
        p1.req_valid = 1'b0; p1.req_addr = '0; p1.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom_mem[i]     = 16'h1100 + 16'(i);
            rom_err_mem[i] = 1'b0;
        end
        rom_mem[8'h10]     = 16'hBEEF;
        rom_err_mem[8'h05] = 1'b1;

        // Vector script: contention, single read, error paths
        for (int k = 0; k < 12; k += 6) begin
            vecs[k+0] = mk(1, 8'h01, 1, 8'h02, 1, 1, 1, 0, 0, 0, 0, 0, 0, (k == 0) ? 8'h00 : 8'h02, 16'h0);
            vecs[k+1] = mk(1, 8'h01, 1, 8'h02, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h01, 16'h0);
            vecs[k+2] = mk(1, 8'h01, 1, 8'h02, 1, 1, 0, 0, 1, 0, 1, 0, 0, 8'h01, 16'h1101);
            vecs[k+3] = mk(1, 8'h01, 1, 8'h02, 1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h01, 16'h0);
            vecs[k+4] = mk(1, 8'h01, 1, 8'h02, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h02, 16'h0);
            vecs[k+5] = mk(1, 8'h01, 1, 8'h02, 1, 1, 0, 0, 0, 1, 1, 0, 0, 8'h02, 16'h1102);
        end
        vecs[12] = mk(1, 8'h10, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h02, 16'h0);
        vecs[13] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h10, 16'h0);
        vecs[14] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 0, 8'h10, 16'hBEEF);
        vecs[15] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h10, 16'h0);
        vecs[16] = mk(0, 8'h00, 1, 8'h05, 1, 1, 0, 1, 0, 0, 0, 0, 0, 8'h10, 16'h0);
        vecs[17] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h05, 16'h0);
        vecs[18] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0, 1, 8'h05, 16'h1105);
        vecs[19] = mk(1, 8'h40, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h05, 16'h0);
        vecs[20] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h40, 16'h0);
        vecs[21] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 1, 0, 8'h40, 16'h1140);
        vecs[22] = mk(1, 8'h06, 0, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h40, 16'h0);
        vecs[23] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h06, 16'h0);
        vecs[24] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1, 0, 0, 8'h06, 16'h1106);
        vecs[25] = mk(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'h06, 16'h0);

        // Reset held with both requesters active
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 8'h01, 1, 8'h02, 1, 1);
            checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0);
        end

        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(0, vecs[k].v0, vecs[k].a0, vecs[k].v1, vecs[k].a1,
                          vecs[k].rr0, vecs[k].rr1);
            checkOutput($sformatf("vec%0d", k), vecs[k].e_rdy0, vecs[k].e_rdy1,
                        vecs[k].e_rv0, vecs[k].e_rv1, vecs[k].e_busy,
                        vecs[k].e_err0, vecs[k].e_err1, vecs[k].e_addr, vecs[k].e_data);
        end

        // Response backpressure on port 1 while port 0 keeps requesting
        applyStimulus(0, 0, 8'h00, 1, 8'h02, 1, 0);
        checkOutput("bp_accept", 0, 1, 0, 0, 0, 0, 0, 8'h06, 16'h0);
        applyStimulus(0, 1, 8'h01, 0, 8'h00, 1, 0);
        checkOutput("bp_access", 0, 0, 0, 0, 1, 0, 0, 8'h02, 16'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 8'h01, 0, 8'h00, 1, 0);
            checkOutput($sformatf("bp_hold%0d", i), 0, 0, 0, 1, 1, 0, 0, 8'h02, 16'h1102);
        end
        applyStimulus(0, 1, 8'h01, 0, 8'h00, 1, 1);
        checkOutput("bp_release", 0, 0, 0, 1, 1, 0, 0, 8'h02, 16'h1102);
        applyStimulus(0, 1, 8'h01, 0, 8'h00, 1, 1);
        checkOutput("bp_next_grant", 1, 0, 0, 0, 0, 0, 0, 8'h02, 16'h0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("bp_p0_access", 0, 0, 0, 0, 1, 0, 0, 8'h01, 16'h0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 1);
        checkOutput("bp_p0_resp", 0, 0, 1, 0, 1, 0, 0, 8'h01, 16'h1101);

        // Reset pulse while port 0 holds a response, port 1 pending
        applyStimulus(0, 1, 8'h10, 0, 8'h00, 0, 0);
        checkOutput("mr_accept", 1, 0, 0, 0, 0, 0, 0, 8'h01, 16'h0);
        applyStimulus(0, 1, 8'h01, 1, 8'h02, 0, 0);
        checkOutput("mr_access", 0, 0, 0, 0, 1, 0, 0, 8'h10, 16'h0);
        applyStimulus(1, 1, 8'h01, 1, 8'h02, 0, 0);
        checkOutput("mr_resp_in_reset", 0, 0, 1, 0, 1, 0, 0, 8'h10, 16'hBEEF);
        applyStimulus(0, 1, 8'h01, 1, 8'h02, 0, 0);
        checkOutput("mr_after_reset", 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 256; i++) begin
            rom_mem[i]     = 16'($urandom);
            rom_err_mem[i] = ($urandom_range(0, 7) == 0);
        end
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);
        m_busy = 0; m_in_access = 0; m_port = 0; m_last = 1;
        m_addr = '0; m_data = '0; m_err = 0;
        pend0 = 0; pend1 = 0; a0 = '0; a1 = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!pend0) begin
                v0 = ($urandom_range(0, 2) == 0);
                a0 = 8'($urandom_range(0, 63));
            end else begin
                v0 = 1;
            end
            if (!pend1) begin
                v1 = ($urandom_range(0, 2) == 0);
                a1 = 8'($urandom_range(0, 63));
            end else begin
                v1 = 1;
            end
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            applyStimulus(0, v0, a0, v1, a1, rr0, rr1);

            gv = v0 | v1;
            g  = (v0 && v1) ? !m_last : v1;
            e_rdy0 = !m_busy && gv && !g;
            e_rdy1 = !m_busy && gv && g;
            e_rv0  = m_busy && !m_in_access && !m_port;
            e_rv1  = m_busy && !m_in_access && m_port;
            e_err0 = e_rv0 && m_err;
            e_err1 = e_rv1 && m_err;
            checkOutput($sformatf("rand%0d", c), e_rdy0, e_rdy1, e_rv0, e_rv1, m_busy,
                        e_err0, e_err1, m_addr, m_data);

            if (!m_busy) begin
                pend0 = v0;
                pend1 = v1;
                if (gv) begin
                    m_busy      = 1;
                    m_in_access = 1;
                    m_port      = g;
                    m_addr      = g ? a1 : a0;
                    m_data      = rom_mem[m_addr];
                    m_err       = rom_err_mem[m_addr] || (m_addr >= 8'(DEPTH));
                    if (g) pend1 = 0; else pend0 = 0;
                end
            end else begin
                pend0 = v0;
                pend1 = v1;
                if (m_in_access) begin
                    m_in_access = 0;
                end else if (m_port ? rr1 : rr0) begin
                    m_busy = 0;
                    m_last = m_port;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
